// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared types and constants for the detector test sequencer
package fsm_seq_pkg;

   // Controller phases of one stimulus run
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RST_TGT = 3'd1,
      RUN     = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } seq_state_t;

   // One stored stimulus vector: target inputs and the expected Moore output
   typedef struct packed {
      logic x;
      logic y;
      logic z;
   } seq_vec_t;

   localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/seq_vec_mem.sv
// rtl/seq_vec_mem.sv - DEPTH x 3 vector register file, sync write, async read
module seq_vec_mem
   import fsm_seq_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  seq_vec_t      i_wdata,
   input  logic [AW-1:0] i_raddr,
   output seq_vec_t      o_rdata
);

   seq_vec_t r_mem [DEPTH];

   // Storage is not reset; the controller's count decides what is valid
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fsm_test_sequencer.sv
// rtl/fsm_test_sequencer.sv - stores vectors, resets and drives the detector, counts mismatches
module fsm_test_sequencer
   import fsm_seq_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_valid,
   input  logic          load_x,
   input  logic          load_y,
   input  logic          load_z,
   output logic          load_ready,
   input  logic          clear,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [CW-1:0] err_count,
   output logic          fsm_x,
   output logic          fsm_y,
   output logic          fsm_reset_b,
   input  logic          fsm_z
);

   seq_state_t    r_state, w_nx_state;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_rd_idx;
   logic [CW-1:0] r_err;
   logic          r_fsm_x, r_fsm_y, r_fsm_reset_b;
   logic          r_cur_z, r_cur_vld;   // expectation travelling with the presented vector
   logic          r_exp_z_d, r_cmp_vld; // same, one cycle later, when the target has reacted

   logic          w_load_ready, w_we, w_start_ok, w_clear_ok, w_present;
   logic          w_nx_x, w_nx_y, w_nx_rstb, w_nx_cur_z;
   seq_vec_t      w_rd_vec, w_wr_vec;

   assign w_wr_vec = '{x: load_x, y: load_y, z: load_z};

   seq_vec_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_count[AW-1:0]),
      .i_wdata (w_wr_vec),
      .i_raddr (r_rd_idx[AW-1:0]),
      .o_rdata (w_rd_vec)
   );

   // Next state and the values the registered target drive will take next cycle
   always_comb begin
      w_nx_state   = r_state;
      w_load_ready = 1'b0;
      w_we         = 1'b0;
      w_start_ok   = 1'b0;
      w_clear_ok   = 1'b0;
      w_present    = 1'b0;
      w_nx_x       = 1'b0;
      w_nx_y       = 1'b0;
      w_nx_rstb    = 1'b1;
      w_nx_cur_z   = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (r_state == IDLE) begin
               w_load_ready = (r_count < CW'(DEPTH));
            end
            if (clear) begin
               w_clear_ok = 1'b1;
               w_nx_state = IDLE;
            end else if (start) begin
               w_start_ok = 1'b1;
               if (r_count == '0) begin
                  w_nx_state = DONE;
               end else begin
                  w_nx_state = RST_TGT;
                  w_nx_rstb  = 1'b0;
               end
            end else if (load_valid && w_load_ready) begin
               w_we = 1'b1;
            end
         end
         RST_TGT, RUN: begin
            if (r_rd_idx == r_count) begin
               w_nx_state = DRAIN;
            end else begin
               w_nx_state = RUN;
               w_present  = 1'b1;
               w_nx_x     = w_rd_vec.x;
               w_nx_y     = w_rd_vec.y;
               w_nx_cur_z = w_rd_vec.z;
            end
         end
         DRAIN: begin
            w_nx_state = DONE;
         end
         default: begin
            w_nx_state = IDLE;
         end
      endcase
   end

   // Controller registers, pointers, target drive and compare pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_count       <= '0;
         r_rd_idx      <= '0;
         r_err         <= '0;
         r_fsm_x       <= 1'b0;
         r_fsm_y       <= 1'b0;
         r_fsm_reset_b <= 1'b1;
         r_cur_z       <= 1'b0;
         r_cur_vld     <= 1'b0;
         r_exp_z_d     <= 1'b0;
         r_cmp_vld     <= 1'b0;
      end else begin
         r_state       <= w_nx_state;
         r_fsm_x       <= w_nx_x;
         r_fsm_y       <= w_nx_y;
         r_fsm_reset_b <= w_nx_rstb;
         r_cur_z       <= w_nx_cur_z;
         r_cur_vld     <= w_present;
         r_exp_z_d     <= r_cur_z;
         r_cmp_vld     <= r_cur_vld;
         if (w_clear_ok) begin
            r_count <= '0;
            r_err   <= '0;
         end else if (w_start_ok) begin
            r_err    <= '0;
            r_rd_idx <= '0;
         end else if (w_we) begin
            r_count <= r_count + 1'b1;
         end
         if (w_present) begin
            r_rd_idx <= r_rd_idx + 1'b1;
         end
         if (r_cmp_vld && (fsm_z != r_exp_z_d)) begin
            r_err <= r_err + 1'b1;
         end
      end
   end

   assign load_ready  = w_load_ready;
   assign busy        = (r_state == RST_TGT) || (r_state == RUN) || (r_state == DRAIN);
   assign done        = (r_state == DONE);
   assign pass        = (r_state == DONE) && (r_err == '0);
   assign err_count   = r_err;
   assign fsm_x       = r_fsm_x;
   assign fsm_y       = r_fsm_y;
   assign fsm_reset_b = r_fsm_reset_b;

endmodule
